// File: rtl/alu_issue_unit.sv
// Issue front end for an external combinational ALU: handshake, operand read, execute, writeback.
// Optional flag outputs (flag_z, flag_n) are built when ALU_ISSUE_FLAGS_EN is defined.
module alu_issue_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_opa,
  output logic [DATA_W-1:0] alu_opb,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_op,
  output logic              busy
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] OP_LAST = 3'b100;

  state_t            state;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [IMM_W-1:0]  imm_q;
  logic              use_imm_q;
  logic              handshake;

  // in_ready is combinational so it is high in IDLE as soon as rst drops, not one edge later.
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign handshake = in_valid && in_ready;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      rf_raddr1  <= '0;
      rf_raddr2  <= '0;
      alu_opa    <= '0;
      alu_opb    <= '0;
      alu_sel    <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      illegal_op <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
`endif
    end else begin
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            op_q      <= in_op;
            rd_q      <= in_rd;
            imm_q     <= in_imm;
            use_imm_q <= in_use_imm;
            rf_raddr1 <= in_rs1;
            rf_raddr2 <= in_rs2;
            if (in_op > OP_LAST) illegal_op <= 1'b1;
            else                 state      <= READ;
          end
        end
        READ: begin
          // Operand registers feed the ALU directly so its result is stable throughout EXEC.
          alu_opa <= rf_rdata1;
          alu_opb <= use_imm_q ? DATA_W'(imm_q) : rf_rdata2;
          alu_sel <= op_q;
          state   <= EXEC;
        end
        EXEC: begin
          wb_data <= alu_result;
          wb_addr <= rd_q;
          if (rd_q == '0) begin
            state <= IDLE;
`ifdef ALU_ISSUE_FLAGS_EN
            flag_z <= (alu_result == '0);
            flag_n <= alu_result[DATA_W-1];
`endif
          end else begin
            wb_valid <= 1'b1;
            state    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
`ifdef ALU_ISSUE_FLAGS_EN
            flag_z   <= (wb_data == '0);
            flag_n   <= wb_data[DATA_W-1];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural register file and ALU around it.
// Define ALU_ISSUE_FLAGS_EN for both bench and RTL to cover the flag outputs.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] alu_opa, alu_opb;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal_op, busy;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  logic [31:0] rf [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  always_comb begin
    alu_result = '0;
    case (alu_sel)
      3'b000: alu_result = alu_opa + alu_opb;
      3'b001: alu_result = alu_opa - alu_opb;
      3'b010: alu_result = alu_opa * alu_opb;
      3'b011: alu_result = alu_opa >> alu_opb[4:0];
      3'b100: alu_result = alu_opa & alu_opb;
      default: alu_result = '0;
    endcase
  end

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_op(illegal_op), .busy(busy)
`ifdef ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  // Presents one instruction for a single edge; returns at the negedge after the handshake (READ).
  task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [15:0] imm, input logic use_imm);
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = use_imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_use_imm = 1'b0; wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if ({alu_opa, alu_opb, alu_sel, wb_addr, wb_data} !== '0) begin errors++;
      $display("FAIL reset_datapath got opa=%h opb=%h sel=%h addr=%h data=%h exp all 0", alu_opa, alu_opb, alu_sel, wb_addr, wb_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add_reg;
    rf[1] = 32'd5; rf[2] = 32'd7; wb_ready = 1'b1;
    issue(3'b000, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0);
    checks++; if ({busy, in_ready, wb_valid} !== 3'b100) begin errors++; $display("FAIL add_read busy/in_ready/wb_valid got=%b exp=100", {busy, in_ready, wb_valid}); end
    checks++; if ({rf_raddr1, rf_raddr2} !== 8'h12) begin errors++; $display("FAIL add_raddr got=%h exp=12", {rf_raddr1, rf_raddr2}); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_exec_wb_valid got=%b exp=0", wb_valid); end
    checks++; if ({alu_opa, alu_opb, alu_sel} !== {32'd5, 32'd7, 3'b000}) begin errors++;
      $display("FAIL add_alu_ops got opa=%h opb=%h sel=%h exp 5 7 0", alu_opa, alu_opb, alu_sel); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_addr, wb_data} !== {1'b1, 4'd3, 32'd12}) begin errors++;
      $display("FAIL add_wb got valid=%b addr=%h data=%h exp 1 3 0000000c", wb_valid, wb_addr, wb_data); end
    @(negedge clk);
    checks++; if ({wb_valid, in_ready, busy} !== 3'b010) begin errors++; $display("FAIL add_done wb_valid/in_ready/busy got=%b exp=010", {wb_valid, in_ready, busy}); end
  endtask

  task automatic test_sub_imm_stall;
    int valid_cycles = 0;
    rf[1] = 32'h10; wb_ready = 1'b0;
    issue(3'b001, 4'd2, 4'd1, 4'd9, 16'h0011, 1'b1);
    @(negedge clk);
    // Junk instruction offered during the stall must be ignored.
    in_valid = 1'b1; in_op = 3'b000; in_rd = 4'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) valid_cycles++;
      checks++; if ({wb_addr, wb_data, in_ready} !== {4'd2, 32'hFFFF_FFFF, 1'b0}) begin errors++;
        $display("FAIL sub_stall[%0d] got addr=%h data=%h in_ready=%b exp 2 ffffffff 0", i, wb_addr, wb_data, in_ready); end
      if (i == 5) begin wb_ready = 1'b1; in_valid = 1'b0; end
    end
    checks++; if (valid_cycles !== 6) begin errors++; $display("FAIL sub_valid_cycles got=%0d exp=6", valid_cycles); end
    @(negedge clk);
    checks++; if ({wb_valid, in_ready, busy} !== 3'b010) begin errors++; $display("FAIL sub_done wb_valid/in_ready/busy got=%b exp=010", {wb_valid, in_ready, busy}); end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++; if ({flag_n, flag_z} !== 2'b10) begin errors++; $display("FAIL sub_flags n/z got=%b exp=10", {flag_n, flag_z}); end
`endif
  endtask

  task automatic test_illegal;
    int wb_seen = 0;
    wb_ready = 1'b1;
    issue(3'b110, 4'd4, 4'd1, 4'd2, 16'h0, 1'b0);
    checks++; if ({illegal_op, busy, in_ready} !== 3'b101) begin errors++; $display("FAIL illegal_pulse illegal/busy/in_ready got=%b exp=101", {illegal_op, busy, in_ready}); end
    @(negedge clk);
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle got=%b exp=0", illegal_op); end
    for (int i = 0; i < 3; i++) begin
      if (wb_valid === 1'b1) wb_seen++;
      @(negedge clk);
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL illegal_no_wb got=%0d exp=0", wb_seen); end
  endtask

  task automatic test_rd0_discard;
    int wb_seen = 0;
    rf[1] = 32'hF0; rf[2] = 32'h0F; wb_ready = 1'b1;
    issue(3'b100, 4'd0, 4'd1, 4'd2, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (wb_valid === 1'b1) wb_seen++;
      @(negedge clk);
    end
    if (wb_valid === 1'b1) wb_seen++;
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL rd0_no_wb got=%0d exp=0", wb_seen); end
    checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL rd0_idle busy/in_ready got=%b exp=01", {busy, in_ready}); end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++; if ({flag_n, flag_z} !== 2'b01) begin errors++; $display("FAIL rd0_flags n/z got=%b exp=01", {flag_n, flag_z}); end
`endif
  endtask

  task automatic test_reset_in_exec;
    int wb_seen = 0;
    rf[1] = 32'd3; rf[2] = 32'd4; wb_ready = 1'b1;
    issue(3'b010, 4'd5, 4'd1, 4'd2, 16'h0, 1'b0);
    @(negedge clk);
    checks++; if ({alu_opa, alu_opb, alu_sel} !== {32'd3, 32'd4, 3'b010}) begin errors++;
      $display("FAIL mul_exec_ops got opa=%h opb=%h sel=%h exp 3 4 2", alu_opa, alu_opb, alu_sel); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({in_ready, busy, wb_valid, illegal_op, alu_opa, alu_opb, alu_sel, wb_addr, wb_data} !== '0) begin errors++;
      $display("FAIL rst_exec_outputs got in_ready=%b busy=%b wb_valid=%b illegal=%b opa=%h opb=%h sel=%h addr=%h data=%h exp all 0",
               in_ready, busy, wb_valid, illegal_op, alu_opa, alu_opb, alu_sel, wb_addr, wb_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) wb_seen++;
    end
    checks++; if (wb_seen !== 0) begin errors++; $display("FAIL rst_exec_no_wb got=%0d exp=0", wb_seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int hs_cyc [2];
    int n_hs = 0;
    logic [31:0] wb_d [2];
    logic [3:0]  wb_a [2];
    int n_wb = 0;
    rf[1] = 32'h80; rf[4] = 32'd6; rf[5] = 32'd7; wb_ready = 1'b1;
    @(negedge clk);
    in_op = 3'b011; in_rd = 4'd1; in_rs1 = 4'd1; in_rs2 = 4'd0; in_imm = 16'd3; in_use_imm = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (wb_valid === 1'b1 && n_wb < 2) begin wb_d[n_wb] = wb_data; wb_a[n_wb] = wb_addr; n_wb++; end
      if (in_ready === 1'b1 && in_valid && n_hs < 2) begin
        hs_cyc[n_hs] = c; n_hs++;
      end else if (n_hs == 1) begin
        in_op = 3'b010; in_rd = 4'd2; in_rs1 = 4'd4; in_rs2 = 4'd5; in_imm = 16'h0; in_use_imm = 1'b0;
      end else if (n_hs == 2) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (n_hs !== 2) begin errors++; $display("FAIL b2b_handshakes got=%0d exp=2", n_hs); end
    else begin
      checks++; if (hs_cyc[1] - hs_cyc[0] !== 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", hs_cyc[1] - hs_cyc[0]); end
    end
    checks++; if (n_wb !== 2) begin errors++; $display("FAIL b2b_wb_count got=%0d exp=2", n_wb); end
    else begin
      checks++; if ({wb_a[0], wb_d[0]} !== {4'd1, 32'h10}) begin errors++; $display("FAIL b2b_wb0 got addr=%h data=%h exp 1 00000010", wb_a[0], wb_d[0]); end
      checks++; if ({wb_a[1], wb_d[1]} !== {4'd2, 32'd42}) begin errors++; $display("FAIL b2b_wb1 got addr=%h data=%h exp 2 0000002a", wb_a[1], wb_d[1]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_add_reg();
    test_sub_imm_stall();
    test_illegal();
    test_rd0_discard();
    test_reset_in_exec();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
